dig_pot_mc: RTL and testbench
=============================

// Module: dig_pot_mc
// PURPOSE
//  Parametrised multi-channel SPI digital potentiometer model; successor to the 2-wiper pot.
//  Decodes 16-bit SPI frames into per-channel write/inc/dec/read/shutdown commands.
//  Optional slew-limited ramping of each wiper toward its target.
//  Sits on the DSO analog-front-end SPI bus; wiper codes drive offset/gain models.
// PARAMETERS
//  NUM_WIPERS  4     channel count, 1..8
//  WIPER_W     8     wiper code width, 1..8; data taken from cmd[WIPER_W-1:0]
//  RESET_CODE  2**(WIPER_W-1)  reset wiper/target value (mid rail)
// PORTS
//  clk      in   1                   system clock; single clock domain
//  rst      in   1                   reset, asynchronous, active-high
//  SCLK     in   1                   SPI clock
//  SS_n     in   1                   SPI slave select, active low
//  MOSI     in   1                   SPI serial data in
//  MISO     out  1                   SPI serial data out (read responses)
//  wipe     out  NUM_WIPERS*WIPER_W  wiper codes; channel i at [i*WIPER_W +: WIPER_W]
//  busy     out  1                   1 while any wiper != its target
//  cmd_err  out  1                   sticky; set by bad opcode/address, cleared by CLR_ERR
// BEHAVIOUR
//  Frame: cmd[15:12]=opcode, cmd[11:9]=addr, cmd[8]=rsvd, cmd[7:0]=data.
//  Command accepted once per rising edge of SPI cmd_rdy (cmd_rdy flopped for edge detect).
//  Registers update on the clk edge that samples the edge: 1-cycle latency.
//  Opcodes: 0 NOP; 1 WRITE tgt[a]=data; 2 INC tgt[a]+1, saturate at 2**WIPER_W-1;
//   3 DEC tgt[a]-1, saturate at 0; 4 READ; 5 WRITE_ALL every tgt=data;
//   6 SHDN shdn[a]=data[0]; 7 RAMP ramp_div=data; 8 CLR_ERR cmd_err=0.
//   Opcodes 9..15 and addr>=NUM_WIPERS (ops 1,2,3,4,6): no state change, cmd_err=1.
//  INC/DEC act on target, not on the current wipe value.
//  Ramp: ramp_div==0 -> wipe[a] loads target on the same edge as target.
//   ramp_div=D>0 -> prescaler ticks once every D+1 clks; on each tick every
//   wiper with wipe!=tgt steps 1 LSB toward tgt. Prescaler free-runs while busy,
//   cleared to 0 when busy==0 and when RAMP is written.
//  Retarget mid-ramp: tgt updated, wipe continues from current value, no jump.
//  SHDN: wipe output forced to 0 while shdn=1; stored wipe/tgt keep updating.
//   busy ignores shdn.
//  READ: tx_data={4'h4,addr,1'b0,zero-pad,wipe[a] unforced}; wrt pulsed 1 cycle
//   after decode; data shifted out on MISO during the next frame. Other frames return 0.
//  Reset: wipe=tgt=RESET_CODE, shdn=0, ramp_div=0, prescaler=0, busy=0,
//   cmd_err=0, cmd_rdy_ff=0. A partial SPI frame in flight is discarded.
//  Simultaneous ramp tick and command on the same channel: command wins for tgt;
//   wipe takes the tick step (WRITE with ramp_div==0 loads wipe directly).
// STRUCTURE
//  dig_pot_pkg: opcode localparams, field positions (OP_MSB..), READ response tag 4'h4.
//  SPI_slv front end reused as-is, rst_n driven by ~rst.
//  Sub-module dig_pot_chan: one channel (tgt, wipe, shdn, saturating inc/dec, step
//   logic); generate-instantiated NUM_WIPERS times. Top holds decode, prescaler,
//   cmd_err, read mux.
// TESTING
//  1 Reset -> all wipe=0x80, busy=0, cmd_err=0, MISO frames read 0x0000.
//  2 WRITE ch2=0x3C, ramp 0 -> wipe ch2=0x3C 1 clk after cmd_rdy edge; other channels stay 0x80.
//  3 WRITE ch0=0xFF then INC ch0 -> 0xFF; WRITE 0x00 then DEC -> 0x00; cmd_err stays 0.
//  4 RAMP D=3, WRITE ch1=0x84 -> ch1 steps 0x81..0x84, one step per 4 clks; busy high 16 clks.
//  5 SHDN ch3=1 -> wipe ch3=0; READ ch3 then a NOP frame -> MISO returns 0x4600|0x80;
//    SHDN=0 restores 0x80.
//  6 Opcode 0xB, then WRITE addr 5 with NUM_WIPERS=4 -> cmd_err=1, no wipe change;
//    CLR_ERR -> 0; assert rst mid-ramp -> all outputs at reset values.

Source files
------------

// File: rtl/dig_pot_pkg.sv
// Shared definitions for the multi-channel SPI digital potentiometer.
// Opcodes, command field positions and the READ response tag.
package dig_pot_pkg;

    localparam int OP_MSB   = 15;
    localparam int OP_LSB   = 12;
    localparam int ADDR_MSB = 11;
    localparam int ADDR_LSB = 9;
    localparam int RSVD_BIT = 8;
    localparam int DATA_MSB = 7;

    localparam logic [3:0] OP_NOP       = 4'd0;
    localparam logic [3:0] OP_WRITE     = 4'd1;
    localparam logic [3:0] OP_INC       = 4'd2;
    localparam logic [3:0] OP_DEC       = 4'd3;
    localparam logic [3:0] OP_READ      = 4'd4;
    localparam logic [3:0] OP_WRITE_ALL = 4'd5;
    localparam logic [3:0] OP_SHDN      = 4'd6;
    localparam logic [3:0] OP_RAMP      = 4'd7;
    localparam logic [3:0] OP_CLR_ERR   = 4'd8;

    localparam logic [3:0] READ_TAG = 4'h4;

endpackage

// File: rtl/dig_pot_chan.sv
// One potentiometer channel: target, wiper, shutdown flag.
// Saturating inc/dec on the target; wiper follows directly or by ramp ticks.
module dig_pot_chan #(
    parameter int WIPER_W    = 8,
    parameter int RESET_CODE = 2 ** (WIPER_W - 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr,
    input  logic               inc,
    input  logic               dec,
    input  logic               shdn_we,
    input  logic [WIPER_W-1:0] data,
    input  logic               direct,
    input  logic               tick,
    output logic [WIPER_W-1:0] wipe,
    output logic [WIPER_W-1:0] wipe_raw,
    output logic               busy
);

    localparam logic [WIPER_W-1:0] RST_CODE = WIPER_W'(RESET_CODE);
    localparam logic [WIPER_W-1:0] MAX_CODE = '1;

    logic [WIPER_W-1:0] tgt;
    logic [WIPER_W-1:0] tgt_nxt;
    logic [WIPER_W-1:0] wipe_q;
    logic               shdn;

    assign wipe_raw = wipe_q;
    assign wipe     = shdn ? '0 : wipe_q;
    assign busy     = (wipe_q != tgt);

    // Next target from the command strobes, saturating at both rails
    always_comb begin
        tgt_nxt = tgt;
        if (wr)
            tgt_nxt = data;
        else if (inc && tgt != MAX_CODE)
            tgt_nxt = tgt + 1'b1;
        else if (dec && tgt != '0)
            tgt_nxt = tgt - 1'b1;
    end

    // Target, shutdown and wiper state; wiper steps toward the old target
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tgt    <= RST_CODE;
            wipe_q <= RST_CODE;
            shdn   <= 1'b0;
        end else begin
            tgt <= tgt_nxt;
            if (shdn_we)
                shdn <= data[0];
            if (direct)
                wipe_q <= tgt_nxt;
            else if (tick && wipe_q != tgt)
                wipe_q <= (wipe_q < tgt) ? wipe_q + 1'b1 : wipe_q - 1'b1;
        end
    end

endmodule

// File: rtl/dig_pot_spi.sv
// SPI slave front end (mode 0, MSB first, 16-bit frames) in the clk domain.
// A frame is delivered on cmd/cmd_rdy only if exactly 16 SCLK rises were seen.
module SPI_slv (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    input  logic        wrt,
    input  logic [15:0] tx_data,
    output logic [15:0] cmd,
    output logic        cmd_rdy
);

    logic        sclk_s1, sclk_s2, sclk_s3;
    logic        ss_s1, ss_s2, ss_s3;
    logic        mosi_s1, mosi_s2;
    logic [15:0] rx_sr;
    logic [15:0] tx_sr;
    logic [4:0]  bit_cnt;
    logic        sclk_rise, sclk_fall, ss_rise, ss_fall;

    assign sclk_rise = sclk_s2 & ~sclk_s3;
    assign sclk_fall = ~sclk_s2 & sclk_s3;
    assign ss_rise   = ss_s2 & ~ss_s3;
    assign ss_fall   = ~ss_s2 & ss_s3;
    assign MISO      = tx_sr[15];

    // Bring the asynchronous SPI pins into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {sclk_s1, sclk_s2, sclk_s3} <= 3'b000;
            {ss_s1, ss_s2, ss_s3}       <= 3'b111;
            {mosi_s1, mosi_s2}          <= 2'b00;
        end else begin
            {sclk_s1, sclk_s2, sclk_s3} <= {SCLK, sclk_s1, sclk_s2};
            {ss_s1, ss_s2, ss_s3}       <= {SS_n, ss_s1, ss_s2};
            {mosi_s1, mosi_s2}          <= {MOSI, mosi_s1};
        end
    end

    // Shift MOSI in on SCLK rise and count bits of the current frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sr   <= '0;
            bit_cnt <= '0;
        end else if (ss_fall) begin
            bit_cnt <= '0;
        end else if (!ss_s2 && sclk_rise) begin
            rx_sr <= {rx_sr[14:0], mosi_s2};
            if (bit_cnt != 5'd31)
                bit_cnt <= bit_cnt + 5'd1;
        end
    end

    // Publish a complete frame when slave select is released
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd     <= '0;
            cmd_rdy <= 1'b0;
        end else if (ss_fall) begin
            cmd_rdy <= 1'b0;
        end else if (ss_rise && bit_cnt == 5'd16) begin
            cmd     <= rx_sr;
            cmd_rdy <= 1'b1;
        end
    end

    // Load the response and shift it out on SCLK fall; zeros follow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tx_sr <= '0;
        else if (wrt)
            tx_sr <= tx_data;
        else if (!ss_s2 && sclk_fall)
            tx_sr <= {tx_sr[14:0], 1'b0};
    end

endmodule

// File: rtl/dig_pot_mc.sv
// Multi-channel SPI digital potentiometer top.
// Command decode, ramp prescaler, sticky error flag and READ response.
module dig_pot_mc
    import dig_pot_pkg::*;
#(
    parameter int NUM_WIPERS = 4,
    parameter int WIPER_W    = 8,
    parameter int RESET_CODE = 2 ** (WIPER_W - 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          SCLK,
    input  logic                          SS_n,
    input  logic                          MOSI,
    output logic                          MISO,
    output logic [NUM_WIPERS*WIPER_W-1:0] wipe,
    output logic                          busy,
    output logic                          cmd_err
);

    localparam logic [3:0] NW = 4'(NUM_WIPERS);

    logic [15:0]        cmd;
    logic               cmd_rdy;
    logic               cmd_rdy_ff;
    logic               accept;
    logic [3:0]         op;
    logic [2:0]         addr;
    logic [WIPER_W-1:0] data;
    logic               cmd_bad;
    logic               cmd_ok;
    logic [7:0]         ramp_div;
    logic [7:0]         presc;
    logic               tick;
    logic               direct;
    logic               wrt;
    logic [15:0]        tx_data;
    logic [7:0]         rd8;
    logic [WIPER_W-1:0] wipe_raw [NUM_WIPERS];
    logic [NUM_WIPERS-1:0] chan_busy;
    logic               unused_bits;

    assign op          = cmd[OP_MSB:OP_LSB];
    assign addr        = cmd[ADDR_MSB:ADDR_LSB];
    assign data        = cmd[WIPER_W-1:0];
    assign unused_bits = ^{cmd[RSVD_BIT], cmd[DATA_MSB:0]};
    assign accept      = cmd_rdy & ~cmd_rdy_ff;
    assign cmd_ok      = accept & ~cmd_bad;
    assign busy        = |chan_busy;
    assign direct      = (ramp_div == 8'd0);
    assign tick        = busy && !direct && (presc == ramp_div);

    SPI_slv u_spi (
        .clk     (clk),
        .rst_n   (~rst),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO),
        .wrt     (wrt),
        .tx_data (tx_data),
        .cmd     (cmd),
        .cmd_rdy (cmd_rdy)
    );

    // Unknown opcodes and out-of-range channel addresses are rejected
    always_comb begin
        cmd_bad = (op > OP_CLR_ERR);
        if ((op inside {OP_WRITE, OP_INC, OP_DEC, OP_READ, OP_SHDN})
            && ({1'b0, addr} >= NW))
            cmd_bad = 1'b1;
    end

    // Unforced wiper value of the addressed channel, zero-padded to 8 bits
    always_comb begin
        rd8 = '0;
        for (int i = 0; i < NUM_WIPERS; i++)
            if (addr == 3'(i))
                rd8[WIPER_W-1:0] = wipe_raw[i];
    end

    // Edge detect on cmd_rdy so each frame is acted on once
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cmd_rdy_ff <= 1'b0;
        else
            cmd_rdy_ff <= cmd_rdy;
    end

    // Ramp divider register and free-running prescaler while busy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ramp_div <= '0;
            presc    <= '0;
        end else if (cmd_ok && op == OP_RAMP) begin
            ramp_div <= cmd[DATA_MSB:0];
            presc    <= '0;
        end else if (!busy || tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 8'd1;
        end
    end

    // Sticky command error, cleared only by CLR_ERR
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cmd_err <= 1'b0;
        else if (accept && cmd_bad)
            cmd_err <= 1'b1;
        else if (cmd_ok && op == OP_CLR_ERR)
            cmd_err <= 1'b0;
    end

    // READ response captured at decode, handed to the SPI slave next cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrt     <= 1'b0;
            tx_data <= '0;
        end else begin
            wrt <= cmd_ok && op == OP_READ;
            if (cmd_ok && op == OP_READ)
                tx_data <= {READ_TAG, addr, 1'b0, rd8};
        end
    end

    for (genvar i = 0; i < NUM_WIPERS; i++) begin : g_chan
        logic sel;
        assign sel = cmd_ok && (addr == 3'(i));

        dig_pot_chan #(
            .WIPER_W    (WIPER_W),
            .RESET_CODE (RESET_CODE)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .wr       ((sel && op == OP_WRITE) || (cmd_ok && op == OP_WRITE_ALL)),
            .inc      (sel && op == OP_INC),
            .dec      (sel && op == OP_DEC),
            .shdn_we  (sel && op == OP_SHDN),
            .data     (data),
            .direct   (direct),
            .tick     (tick),
            .wipe     (wipe[i*WIPER_W +: WIPER_W]),
            .wipe_raw (wipe_raw[i]),
            .busy     (chan_busy[i])
        );
    end

endmodule

// File: tb/tb_dig_pot_mc.sv
// Self-checking bench for dig_pot_mc: directed scenarios plus random
// command streams checked against a settled-state reference model.
module tb_dig_pot_mc;

    localparam int NW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        SCLK;
    logic        SS_n;
    logic        MOSI;
    logic        MISO;
    logic [31:0] wipe;
    logic        busy;
    logic        cmd_err;

    int checks = 0;
    int errors = 0;

    logic [7:0]  m_tgt  [NW];
    logic        m_shdn [NW];
    logic        m_err;
    logic [15:0] m_resp;

    dig_pot_mc #(.NUM_WIPERS(4), .WIPER_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .SCLK    (SCLK),
        .SS_n    (SS_n),
        .MOSI    (MOSI),
        .MISO    (MISO),
        .wipe    (wipe),
        .busy    (busy),
        .cmd_err (cmd_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] wget(input int i);
        return wipe[i*8 +: 8];
    endfunction

    function automatic logic [15:0] mk(input logic [3:0] op,
                                       input logic [2:0] a,
                                       input logic [7:0] d);
        return {op, a, 1'b0, d};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NW; i++) begin
            m_tgt[i]  = 8'h80;
            m_shdn[i] = 1'b0;
        end
        m_err  = 1'b0;
        m_resp = 16'h0000;
    endtask

    task automatic model_apply(input logic [15:0] c);
        int a;
        logic [3:0] op;
        logic [7:0] d;
        op = c[15:12];
        a  = int'(c[11:9]);
        d  = c[7:0];
        if (op > 4'd8 || ((op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd6}) && a >= NW)) begin
            m_err = 1'b1;
            return;
        end
        case (op)
            4'd1: m_tgt[a] = d;
            4'd2: if (m_tgt[a] != 8'hFF) m_tgt[a] = m_tgt[a] + 8'd1;
            4'd3: if (m_tgt[a] != 8'h00) m_tgt[a] = m_tgt[a] - 8'd1;
            4'd4: m_resp = {4'h4, c[11:9], 1'b0, m_tgt[a]};
            4'd5: for (int i = 0; i < NW; i++) m_tgt[i] = d;
            4'd6: m_shdn[a] = d[0];
            4'd8: m_err = 1'b0;
            default: ;
        endcase
    endtask

    task automatic send_frame(input logic [15:0] c, output logic [15:0] rx);
        @(negedge clk);
        SS_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int b = 15; b >= 0; b--) begin
            MOSI = c[b];
            repeat (8) @(negedge clk);
            SCLK  = 1'b1;
            rx[b] = MISO;
            repeat (8) @(negedge clk);
            SCLK = 1'b0;
        end
        repeat (4) @(negedge clk);
        SS_n = 1'b1;
    endtask

    task automatic settle();
        int n;
        repeat (8) @(negedge clk);
        n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL settle: busy=%b after %0d clks, required 0", busy, n);
        end
    endtask

    task automatic do_cmd(input logic [15:0] c,
                          output logic [15:0] rx,
                          output logic [15:0] exp_rx);
        exp_rx = m_resp;
        m_resp = 16'h0000;
        send_frame(c, rx);
        model_apply(c);
        settle();
    endtask

    task automatic test_reset();
        logic [15:0] rx, ex;
        rst  = 1'b1;
        SCLK = 1'b0;
        SS_n = 1'b1;
        MOSI = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        for (int i = 0; i < NW; i++) begin
            checks++;
            if (wget(i) !== 8'h80) begin
                errors++;
                $display("FAIL reset_wipe%0d: got %h want 80", i, wget(i));
            end
        end
        checks++;
        if (busy !== 1'b0 || cmd_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: busy=%b err=%b want 0 0", busy, cmd_err);
        end
        do_cmd(mk(4'd0, 3'd0, 8'h00), rx, ex);
        checks++;
        if (rx !== 16'h0000) begin
            errors++;
            $display("FAIL reset_miso: got %h want 0000", rx);
        end
    endtask

    task automatic test_write();
        logic [15:0] rx, ex;
        logic [7:0] want [NW];
        want = '{8'h80, 8'h80, 8'h3C, 8'h80};
        do_cmd(mk(4'd1, 3'd2, 8'h3C), rx, ex);
        for (int i = 0; i < NW; i++) begin
            checks++;
            if (wget(i) !== want[i]) begin
                errors++;
                $display("FAIL write_ch%0d: got %h want %h", i, wget(i), want[i]);
            end
        end
    endtask

    task automatic test_saturate();
        logic [15:0] rx, ex;
        do_cmd(mk(4'd1, 3'd0, 8'hFF), rx, ex);
        do_cmd(mk(4'd2, 3'd0, 8'h00), rx, ex);
        checks++;
        if (wget(0) !== 8'hFF || cmd_err !== 1'b0) begin
            errors++;
            $display("FAIL inc_sat: wipe=%h err=%b want ff 0", wget(0), cmd_err);
        end
        do_cmd(mk(4'd1, 3'd0, 8'h00), rx, ex);
        do_cmd(mk(4'd3, 3'd0, 8'h00), rx, ex);
        checks++;
        if (wget(0) !== 8'h00 || cmd_err !== 1'b0) begin
            errors++;
            $display("FAIL dec_sat: wipe=%h err=%b want 00 0", wget(0), cmd_err);
        end
    endtask

    task automatic test_ramp();
        logic [15:0] rx, ex;
        int n;
        int k;
        do_cmd(mk(4'd7, 3'd0, 8'd3), rx, ex);
        send_frame(mk(4'd1, 3'd1, 8'h84), rx);
        model_apply(mk(4'd1, 3'd1, 8'h84));
        n = 0;
        while (!busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL ramp_start: busy=%b want 1", busy);
        end
        k = 0;
        while (busy && k < 100) begin
            if (k < 16) begin
                checks++;
                if (wget(1) !== 8'(8'h80 + k / 4)) begin
                    errors++;
                    $display("FAIL ramp_step%0d: got %h want %h", k, wget(1), 8'(8'h80 + k / 4));
                end
            end
            k++;
            @(negedge clk);
        end
        checks++;
        if (k != 16 || wget(1) !== 8'h84) begin
            errors++;
            $display("FAIL ramp_len: busy clks=%0d wipe=%h want 16 84", k, wget(1));
        end
        do_cmd(mk(4'd7, 3'd0, 8'd0), rx, ex);
    endtask

    task automatic test_shdn_read();
        logic [15:0] rx, ex;
        do_cmd(mk(4'd6, 3'd3, 8'h01), rx, ex);
        checks++;
        if (wget(3) !== 8'h00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL shdn_on: wipe=%h busy=%b want 00 0", wget(3), busy);
        end
        do_cmd(mk(4'd4, 3'd3, 8'h00), rx, ex);
        checks++;
        if (rx !== 16'h0000) begin
            errors++;
            $display("FAIL read_frame_miso: got %h want 0000", rx);
        end
        do_cmd(mk(4'd0, 3'd0, 8'h00), rx, ex);
        checks++;
        if (rx !== 16'h4680 || rx !== ex) begin
            errors++;
            $display("FAIL read_resp: got %h want 4680", rx);
        end
        do_cmd(mk(4'd6, 3'd3, 8'h00), rx, ex);
        checks++;
        if (wget(3) !== 8'h80) begin
            errors++;
            $display("FAIL shdn_off: got %h want 80", wget(3));
        end
    endtask

    task automatic test_errors();
        logic [15:0] rx, ex;
        logic [31:0] snap;
        do_cmd(mk(4'hB, 3'd0, 8'h00), rx, ex);
        checks++;
        if (cmd_err !== 1'b1) begin
            errors++;
            $display("FAIL bad_opcode: err=%b want 1", cmd_err);
        end
        do_cmd(mk(4'd8, 3'd0, 8'h00), rx, ex);
        checks++;
        if (cmd_err !== 1'b0) begin
            errors++;
            $display("FAIL clr_err: err=%b want 0", cmd_err);
        end
        snap = wipe;
        do_cmd(mk(4'd1, 3'd5, 8'h11), rx, ex);
        checks++;
        if (cmd_err !== 1'b1 || wipe !== snap) begin
            errors++;
            $display("FAIL bad_addr: err=%b wipe=%h want 1 %h", cmd_err, wipe, snap);
        end
        do_cmd(mk(4'd8, 3'd0, 8'h00), rx, ex);
        checks++;
        if (cmd_err !== 1'b0) begin
            errors++;
            $display("FAIL clr_err2: err=%b want 0", cmd_err);
        end
    endtask

    task automatic test_random();
        logic [15:0] rx, ex, c;
        logic [3:0] op;
        logic [7:0] d;
        logic [7:0] exp_w;
        for (int it = 0; it < 40; it++) begin
            op = 4'($urandom_range(0, 15));
            d  = 8'($urandom);
            if (op == 4'd7)
                d = 8'($urandom_range(0, 2));
            c = mk(op, 3'($urandom_range(0, 7)), d);
            do_cmd(c, rx, ex);
            checks++;
            if (rx !== ex) begin
                errors++;
                $display("FAIL rand_miso it%0d: got %h want %h", it, rx, ex);
            end
            for (int i = 0; i < NW; i++) begin
                exp_w = m_shdn[i] ? 8'h00 : m_tgt[i];
                checks++;
                if (wget(i) !== exp_w) begin
                    errors++;
                    $display("FAIL rand_wipe it%0d ch%0d: got %h want %h", it, i, wget(i), exp_w);
                end
            end
            checks++;
            if (cmd_err !== m_err) begin
                errors++;
                $display("FAIL rand_err it%0d: got %b want %b", it, cmd_err, m_err);
            end
        end
    endtask

    task automatic test_reset_midramp();
        logic [15:0] rx, ex, c;
        int n;
        do_cmd(mk(4'd8, 3'd0, 8'h00), rx, ex);
        do_cmd(mk(4'd5, 3'd0, 8'h80), rx, ex);
        do_cmd(mk(4'd6, 3'd0, 8'h00), rx, ex);
        do_cmd(mk(4'd7, 3'd0, 8'd3), rx, ex);
        do_cmd(mk(4'hC, 3'd0, 8'h00), rx, ex);
        send_frame(mk(4'd1, 3'd0, 8'h00), rx);
        n = 0;
        while (!busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        for (int i = 0; i < NW; i++) begin
            checks++;
            if (wget(i) !== 8'h80) begin
                errors++;
                $display("FAIL midramp_wipe%0d: got %h want 80", i, wget(i));
            end
        end
        checks++;
        if (busy !== 1'b0 || cmd_err !== 1'b0) begin
            errors++;
            $display("FAIL midramp_flags: busy=%b err=%b want 0 0", busy, cmd_err);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        c = mk(4'd1, 3'd1, 8'h22);
        @(negedge clk);
        SS_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int b = 15; b >= 0; b--) begin
            MOSI = c[b];
            if (b == 7) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            repeat (8) @(negedge clk);
            SCLK = 1'b1;
            repeat (8) @(negedge clk);
            SCLK = 1'b0;
        end
        repeat (4) @(negedge clk);
        SS_n = 1'b1;
        settle();
        checks++;
        if (wget(1) !== 8'h80 || cmd_err !== 1'b0) begin
            errors++;
            $display("FAIL partial_frame: wipe=%h err=%b want 80 0", wget(1), cmd_err);
        end
        do_cmd(mk(4'd0, 3'd0, 8'h00), rx, ex);
        checks++;
        if (rx !== 16'h0000) begin
            errors++;
            $display("FAIL post_reset_miso: got %h want 0000", rx);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_saturate();
        test_ramp();
        test_shdn_read();
        test_errors();
        test_random();
        test_reset_midramp();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
